iccm_uart_loader: RTL and testbench



---
 rtl/iccm_loader_pkg.sv | 40 ++++
 rtl/iccm_uart_rx.sv | 97 +++++++++
 rtl/iccm_uart_loader.sv | 199 +++++++++++++++++++
 tb/tb_iccm_uart_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/iccm_loader_pkg.sv
// Shared types and constants for the UART-fed ICCM image loader.
package iccm_loader_pkg;

  // Frame-level states of the loader.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // Error codes reported on err_code_o.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CSUM = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  // Bit-level states of the byte receiver.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Word count is legal when non-zero and no larger than the ICCM capacity.
  function automatic logic len_ok(input logic [15:0] n, input int unsigned aw);
    if (n == 16'd0)  return 1'b0;
    if (aw >= 16)    return 1'b1;
    return ({16'd0, n} <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/iccm_uart_rx.sv
// 8N1 serial byte receiver with 2-flop input synchroniser and runtime baud divider.
module iccm_uart_rx
  import iccm_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_i,
  input  logic [15:0] clks_per_bit_i,
  output logic        rx_valid_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_frame_err_o
);

  logic        r_rx_s1, r_rx_s2;
  rx_state_e   r_state;
  logic [15:0] r_cpb;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_valid;
  logic        r_ferr;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx_i;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // Bit timing: the counter starts at 1 on the detect cycle so the start bit is
  // revalidated at cpb/2 and every later bit is sampled one full cpb later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RX_IDLE;
      r_cpb   <= 16'd0;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_rx_s2) begin
            r_cpb   <= clks_per_bit_i;
            r_cnt   <= 16'd1;
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == (r_cpb >> 1)) begin
            if (!r_rx_s2) begin
              r_state <= RX_DATA;
              r_cnt   <= 16'd1;
              r_bit   <= 3'd0;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == r_cpb) begin
            r_shift <= {r_rx_s2, r_shift[7:1]};
            r_cnt   <= 16'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == r_cpb) begin
            if (r_rx_s2) r_valid <= 1'b1;
            else         r_ferr  <= 1'b1;
            r_state <= RX_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid_o     = r_valid;
  assign rx_byte_o      = r_shift;
  assign rx_frame_err_o = r_ferr;

endmodule

// File: rtl/iccm_uart_loader.sv
// Frame decoder that writes a checksummed serial image into ICCM and gates core reset.
module iccm_uart_loader
  import iccm_loader_pkg::*;
#(
  parameter int         AW          = 12,
  parameter int         DW          = 32,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_i,
  input  logic [15:0]   clks_per_bit_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          core_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [1:0]    err_code_o
);

  localparam int BPW = DW / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  logic          w_rx_valid;
  logic [7:0]    w_rx_byte;
  logic          w_rx_ferr;

  state_e        r_state;
  logic [15:0]   r_len;
  logic [16:0]   r_wcnt;
  logic [AW-1:0] r_waddr;
  logic [BW-1:0] r_bcnt;
  logic [DW-1:0] r_word;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_idle;

  logic          r_we;
  logic [AW-1:0] r_addr_o;
  logic [DW-1:0] r_wdata;
  logic          r_core_rst;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  err_code_e     r_err_code;

  iccm_uart_rx u_rx (
    .clock          (clock),
    .reset          (reset),
    .rx_i           (rx_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_valid_o     (w_rx_valid),
    .rx_byte_o      (w_rx_byte),
    .rx_frame_err_o (w_rx_ferr)
  );

  // Little-endian assembly: each new byte enters at the top and shifts down,
  // so the first byte of a word ends up in bits [7:0].
  logic [DW-1:0] w_word_nxt;
  logic [15:0]   w_len_n;
  logic [7:0]    w_sum_nxt;
  logic          w_last_byte;
  logic          w_last_word;
  logic          w_tmo;
  logic          w_active;

  assign w_word_nxt  = (r_word >> 8) | (DW'(w_rx_byte) << (DW - 8));
  assign w_len_n     = {w_rx_byte, r_len[7:0]};
  assign w_sum_nxt   = r_sum + w_rx_byte;
  assign w_last_byte = (r_bcnt == BW'(BPW - 1));
  assign w_last_word = ((r_wcnt + 17'd1) == {1'b0, r_len});
  assign w_tmo       = (r_idle == TW'(TIMEOUT_CYC - 1));
  assign w_active    = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA)   || (r_state == ST_CSUM);

  // Inter-byte idle counter; only runs while a frame is in progress.
  always_ff @(posedge clock) begin
    if (reset || w_rx_valid || !w_active) r_idle <= '0;
    else                                  r_idle <= r_idle + TW'(1);
  end

  // Frame FSM with registered outputs. A received byte takes priority over a
  // timeout landing in the same cycle; timeout and framing faults apply last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_waddr    <= '0;
      r_bcnt     <= '0;
      r_word     <= '0;
      r_sum      <= '0;
      r_we       <= 1'b0;
      r_addr_o   <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) begin
            r_state    <= ST_LEN_LO;
            r_busy     <= 1'b1;
            r_core_rst <= 1'b1;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_waddr    <= '0;
            r_wcnt     <= '0;
            r_bcnt     <= '0;
            r_sum      <= '0;
          end
        end
        ST_LEN_LO: begin
          if (w_rx_valid) begin
            r_len[7:0] <= w_rx_byte;
            r_sum      <= w_rx_byte;
            r_state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (w_rx_valid) begin
            r_len <= w_len_n;
            r_sum <= w_sum_nxt;
            if (len_ok(w_len_n, AW)) begin
              r_state <= ST_DATA;
            end else begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_err_code <= ERR_LEN;
              r_core_rst <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (w_rx_valid) begin
            r_sum  <= w_sum_nxt;
            r_word <= w_word_nxt;
            if (w_last_byte) begin
              r_we     <= 1'b1;
              r_wdata  <= w_word_nxt;
              r_addr_o <= r_waddr;
              r_waddr  <= r_waddr + AW'(1);
              r_wcnt   <= r_wcnt + 17'd1;
              r_bcnt   <= '0;
              if (w_last_word) r_state <= ST_CSUM;
            end else begin
              r_bcnt <= r_bcnt + BW'(1);
            end
          end
        end
        ST_CSUM: begin
          if (w_rx_valid) begin
            if (w_sum_nxt == 8'd0) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_err_code <= ERR_CSUM;
              r_core_rst <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_active && !w_rx_valid && (w_tmo || w_rx_ferr)) begin
        r_state    <= ST_ERR;
        r_err      <= 1'b1;
        r_err_code <= ERR_TMO;
        r_core_rst <= 1'b1;
        r_busy     <= 1'b0;
      end
    end
  end

  assign we_o       = r_we;
  assign addr_o     = r_addr_o;
  assign wdata_o    = r_wdata;
  assign core_rst_o = r_core_rst;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

endmodule

// File: tb/tb_iccm_uart_loader.sv
// Scoreboard bench for iccm_uart_loader: ICCM writes are queued by the stimulus
// and checked by an independent monitor; status is checked after each frame.
module tb_iccm_uart_loader;
  localparam int          AW  = 12;
  localparam int          DW  = 32;
  localparam int          TMO = 100;
  localparam logic [15:0] CPB = 16'd4;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_i  = 1'b1;
  logic [15:0]   clks_per_bit_i = CPB;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          core_rst_o, busy_o, done_o, err_o;
  logic [1:0]    err_code_o;

  int  errors   = 0;
  int  checks   = 0;
  int  done_cnt = 0;
  wr_t wq[$];

  iccm_uart_loader #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_i           (rx_i),
    .clks_per_bit_i (clks_per_bit_i),
    .we_o           (we_o),
    .addr_o         (addr_o),
    .wdata_o        (wdata_o),
    .core_rst_o     (core_rst_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected write whenever the DUT strobes we_o.
  always @(negedge clock) begin
    wr_t e;
    if (done_o === 1'b1) done_cnt++;
    if (we_o === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h", addr_o, wdata_o);
      end else begin
        e = wq.pop_front();
        if (addr_o !== e.a || wdata_o !== e.d) begin
          errors++;
          $display("FAIL write: got (%0h,%0h), expected (%0h,%0h)", addr_o, wdata_o, e.a, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(posedge clock);
    end
    rx_i = stop;
    repeat (CPB) @(posedge clock);
    rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clock);
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic chk_status(input string tag, input logic e, input logic [1:0] c,
                            input logic cr, input logic bz);
    @(negedge clock);
    chk({tag, "_err"},      err_o,      e);
    chk({tag, "_code"},     err_code_o, c);
    chk({tag, "_core_rst"}, core_rst_o, cr);
    chk({tag, "_busy"},     busy_o,     bz);
    chk({tag, "_wq_empty"}, wq.size(),  0);
  endtask

  // Length 2; 0x02+0x00+0x78+0x56+0x34+0x12+0xEF+0xBE+0xAD+0xDE = 0x44E, so CSUM = 0xB2.
  task automatic good_frame(input string tag, input int exp_done);
    wq.push_back('{a: 12'h000, d: 32'h12345678});
    wq.push_back('{a: 12'h001, d: 32'hDEADBEEF});
    send_seq('{8'hA5, 8'h02, 8'h00});
    @(negedge clock);
    chk({tag, "_mid_core_rst"}, core_rst_o, 1'b1);
    chk({tag, "_mid_busy"},     busy_o,     1'b1);
    send_seq('{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB2});
    repeat (4) @(posedge clock);
    chk_status(tag, 1'b0, 2'd0, 1'b0, 1'b0);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},       we_o,       1'b0);
    chk({tag, "_addr"},     addr_o,     '0);
    chk({tag, "_wdata"},    wdata_o,    '0);
    chk({tag, "_core_rst"}, core_rst_o, 1'b0);
    chk({tag, "_busy"},     busy_o,     1'b0);
    chk({tag, "_done"},     done_o,     1'b0);
    chk({tag, "_err"},      err_o,      1'b0);
    chk({tag, "_code"},     err_code_o, 2'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    @(posedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    good_frame("good1", 1);

    // Bad checksum: writes still land, error 1, core stays in reset.
    wq.push_back('{a: 12'h000, d: 32'h12345678});
    wq.push_back('{a: 12'h001, d: 32'hDEADBEEF});
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB3});
    repeat (4) @(posedge clock);
    chk_status("badcsum", 1'b1, 2'd1, 1'b1, 1'b0);
    chk("badcsum_done_cnt", done_cnt, 1);

    good_frame("good2", 2);

    // Zero length.
    send_seq('{8'hA5, 8'h00, 8'h00});
    repeat (4) @(posedge clock);
    chk_status("len0", 1'b1, 2'd2, 1'b1, 1'b0);

    // Length one past capacity; sync must clear the previous error first.
    send_seq('{8'hA5});
    @(negedge clock);
    chk("len1001_sync_err", err_o,  1'b0);
    chk("len1001_sync_busy", busy_o, 1'b1);
    send_seq('{8'h01, 8'h10});
    repeat (4) @(posedge clock);
    chk_status("len1001", 1'b1, 2'd2, 1'b1, 1'b0);

    // Timeout after the third data byte of a one-word frame.
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33});
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("tmo_early_err",  err_o,  1'b0);
    chk("tmo_early_busy", busy_o, 1'b1);
    repeat (100) @(posedge clock);
    chk_status("tmo", 1'b1, 2'd3, 1'b1, 1'b0);

    // Stop bit held low inside a frame.
    send_seq('{8'hA5, 8'h01, 8'h00});
    @(negedge clock);
    chk("ferr_sync_err", err_o, 1'b0);
    send_byte(8'h55, 1'b0);
    chk_status("ferr", 1'b1, 2'd3, 1'b1, 1'b0);

    good_frame("good3", 3);

    // Noise in IDLE is ignored.
    send_seq('{8'h00, 8'hFF, 8'h5A});
    repeat (4) @(posedge clock);
    chk_status("noise", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("noise_done_cnt", done_cnt, 3);

    // Reset in the middle of the first data word.
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56});
    @(negedge clock);
    chk("rstmid_busy_before", busy_o, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_all_zero("rstmid");
    @(posedge clock);
    reset = 1'b0;
    send_seq('{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB2});
    repeat (4) @(posedge clock);
    chk_status("after_rst", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("after_rst_done_cnt", done_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
